// File: rtl/mips_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control path.
// States, opcodes, ALU operation codes and datapath mux selects; ALU_CU decodes the same alu_op values.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB,
    I_EXEC, I_WB, BRANCH, JUMP, JAL, JR, ILLEGAL, HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  function automatic logic is_mem_wait(input state_t s);
    return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
  endfunction

  function automatic logic [2:0] i_alu_op(input logic [5:0] op);
    case (op)
      OP_SLTI: return ALU_SLT;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Memory wait-state watchdog: counts stalled cycles of one access, expire is combinational in the
// cycle the count reaches TIMEOUT_CYCLES with mem_ready still low; ready in that cycle wins.
module mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic mem_ready,
  output logic expire,
  output logic mem_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt;
  logic             stalled;

  assign stalled = waiting && !mem_ready;
  assign expire  = (TIMEOUT_CYCLES > 0) && stalled && (wait_cnt == LIMIT);

  // Any non-stalled cycle clears the count, so every new access starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (stalled && !expire) wait_cnt <= wait_cnt + CNT_W'(1);
      else                    wait_cnt <= '0;
      if (expire) mem_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: 3-5 cycles per instruction plus one per memory wait state.
// Stalls on mem_ready; the watchdog halts the core if an access never completes.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int OP_W           = 6,
  parameter int FUNCT_W        = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_source,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               illegal_op,
  output logic               mem_timeout,
  output logic [3:0]         state
);

  state_t     cur_st, nxt_st;
  logic [5:0] op, fn;
  logic       expire;

  assign op    = 6'(opcode);
  assign fn    = 6'(funct);
  assign state = cur_st;

  mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .waiting     (is_mem_wait(cur_st)),
    .mem_ready   (mem_ready),
    .expire      (expire),
    .mem_timeout (mem_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_st <= FETCH;
    else        cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st     = cur_st;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = PCSRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    reg_dst    = DST_RT;
    mem_to_reg = M2R_ALUOUT;
    illegal_op = 1'b0;
    case (cur_st)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt_st   = DECODE;
        end else if (expire) begin
          nxt_st = HALT;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (op)
          OP_LW, OP_SW:                     nxt_st = MEM_ADDR;
          OP_RTYPE:                         nxt_st = (fn == FN_JR) ? JR : R_EXEC;
          OP_BEQ, OP_BNE:                   nxt_st = BRANCH;
          OP_J:                             nxt_st = JUMP;
          OP_JAL:                           nxt_st = JAL;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: nxt_st = I_EXEC;
          default:                          nxt_st = ILLEGAL;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        nxt_st    = (op == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready)   nxt_st = MEM_WB;
        else if (expire) nxt_st = HALT;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
        nxt_st     = FETCH;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready)   nxt_st = FETCH;
        else if (expire) nxt_st = HALT;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_RTYPE;
        nxt_st    = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = DST_RD;
        nxt_st    = FETCH;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = i_alu_op(op);
        nxt_st    = I_WB;
      end
      I_WB: begin
        reg_write = 1'b1;
        nxt_st    = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_write  = (op == OP_BNE) ? !alu_zero : alu_zero;
        nxt_st    = FETCH;
      end
      JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
        nxt_st    = FETCH;
      end
      JAL: begin
        pc_source  = PCSRC_JUMP;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = DST_RA;
        mem_to_reg = M2R_PC;
        nxt_st     = FETCH;
      end
      JR: begin
        pc_source = PCSRC_RS;
        pc_write  = 1'b1;
        nxt_st    = FETCH;
      end
      ILLEGAL: begin
        illegal_op = 1'b1;
        nxt_st     = FETCH;
      end
      HALT:    nxt_st = HALT;
      default: nxt_st = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: vector table, random instructions against a per-instruction model,
// and hand-written sequences for reset, watchdog halt and reset during a write.
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  localparam int TMO = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       alu_zero, mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_write, alu_src_a;
  logic       reg_write, illegal_op, mem_timeout;
  logic [1:0] pc_source, alu_src_b, reg_dst, mem_to_reg;
  logic [2:0] alu_op;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.TIMEOUT_CYCLES(TMO), .OP_W(6), .FUNCT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Per-instruction observation: counts of strobe cycles and the selects seen with them.
  typedef struct {
    int cycles, pc_w, pc_src, ir_w, reg_w, reg_dst, m2r, rd_cyc, wr_cyc, ill, alu, halted;
  } obs_t;

  function automatic obs_t model(input logic [5:0] op, input logic [5:0] fn, input logic az,
                                 input int fw, input int mw);
    obs_t e = '{default: 0};
    bit   taken;
    e.cycles = 3 + fw;
    e.pc_w   = 1;
    e.ir_w   = 1;
    e.rd_cyc = fw + 1;
    e.alu    = int'(ALU_ADD);
    case (op)
      OP_LW: begin
        e.cycles = 5 + fw + mw; e.rd_cyc += mw + 1; e.reg_w = 1; e.m2r = 1;
      end
      OP_SW: begin
        e.cycles = 4 + fw + mw; e.wr_cyc = mw + 1;
      end
      OP_RTYPE: begin
        if (fn == FN_JR) begin
          e.pc_w = 2; e.pc_src = 3;
        end else begin
          e.cycles = 4 + fw; e.reg_w = 1; e.reg_dst = 1; e.alu = int'(ALU_RTYPE);
        end
      end
      OP_BEQ, OP_BNE: begin
        taken = (op == OP_BEQ) ? az : !az;
        e.pc_w += int'(taken); e.pc_src = taken ? 1 : 0; e.alu = int'(ALU_SUB);
      end
      OP_J: begin
        e.pc_w = 2; e.pc_src = 2;
      end
      OP_JAL: begin
        e.pc_w = 2; e.pc_src = 2; e.reg_w = 1; e.reg_dst = 2; e.m2r = 2;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        e.cycles = 4 + fw; e.reg_w = 1;
        e.alu = (op == OP_SLTI) ? int'(ALU_SLT) : (op == OP_ANDI) ? int'(ALU_AND) :
                (op == OP_ORI) ? int'(ALU_OR) : int'(ALU_ADD);
      end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  // Starts and ends at a falling edge with the DUT in FETCH; acts as a memory with fixed wait states.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic az,
                           input int fw, input int mw, output obs_t o);
    int fwl = fw;
    int mwl = mw;
    bit seen_ir = 0;
    bit prev_dec = 0;
    bit done = 0;
    o = '{default: 0};
    opcode = op; funct = fn; alu_zero = az;
    for (int c = 0; c < 40 && !done; c++) begin
      if (seen_ir && state == 4'(FETCH)) done = 1;
      else if (state == 4'(HALT)) begin
        o.halted = 1; done = 1;
      end else begin
        if (mem_read || mem_write) begin
          if (!seen_ir) begin mem_ready = (fwl == 0); if (fwl > 0) fwl--; end
          else          begin mem_ready = (mwl == 0); if (mwl > 0) mwl--; end
        end else mem_ready = 1'($urandom_range(0, 1));
        #1;
        o.cycles++;
        if (pc_write)   begin o.pc_w++; o.pc_src = int'(pc_source); end
        if (ir_write)   begin o.ir_w++; seen_ir = 1; end
        if (reg_write)  begin o.reg_w++; o.reg_dst = int'(reg_dst); o.m2r = int'(mem_to_reg); end
        if (mem_read)   o.rd_cyc++;
        if (mem_write)  o.wr_cyc++;
        if (illegal_op) o.ill++;
        if (prev_dec)   o.alu = int'(alu_op);
        prev_dec = (state == 4'(DECODE));
        @(negedge clk);
      end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL run_budget: op %0h still running after 40 cycles, expected to finish", op);
    end
  endtask

  task automatic cmp_obs(input string t, input obs_t a, input obs_t e);
    chk({t, ".cycles"}, a.cycles, e.cycles);  chk({t, ".pc_write_n"}, a.pc_w, e.pc_w);
    chk({t, ".pc_source"}, a.pc_src, e.pc_src); chk({t, ".ir_write_n"}, a.ir_w, e.ir_w);
    chk({t, ".reg_write_n"}, a.reg_w, e.reg_w); chk({t, ".reg_dst"}, a.reg_dst, e.reg_dst);
    chk({t, ".mem_to_reg"}, a.m2r, e.m2r);    chk({t, ".mem_read_n"}, a.rd_cyc, e.rd_cyc);
    chk({t, ".mem_write_n"}, a.wr_cyc, e.wr_cyc); chk({t, ".illegal_n"}, a.ill, e.ill);
    chk({t, ".alu_op"}, a.alu, e.alu);        chk({t, ".halted"}, a.halted, e.halted);
  endtask

  typedef struct {
    logic [5:0] op, fn;
    logic       az;
    int         fw, mw, cycles, pc_w, pc_src, reg_w, reg_dst, m2r, ill;
  } vec_t;

  vec_t       vecs[12];
  logic [5:0] ops[13];

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    obs_t o, e;
    // op, fn, az, fetch waits, mem waits | cycles, pc_writes, last pc_source, reg_writes, reg_dst, mem_to_reg, illegal
    vecs[0]  = '{6'h23, 6'h00, 1'b0, 2, 2,  9, 1, 0, 1, 0, 1, 0};
    vecs[1]  = '{6'h2B, 6'h00, 1'b0, 0, 0,  4, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{6'h00, 6'h20, 1'b0, 1, 0,  5, 1, 0, 1, 1, 0, 0};
    vecs[3]  = '{6'h00, 6'h08, 1'b0, 0, 0,  3, 2, 3, 0, 0, 0, 0};
    vecs[4]  = '{6'h04, 6'h00, 1'b1, 0, 0,  3, 2, 1, 0, 0, 0, 0};
    vecs[5]  = '{6'h05, 6'h00, 1'b1, 0, 0,  3, 1, 0, 0, 0, 0, 0};
    vecs[6]  = '{6'h03, 6'h00, 1'b0, 0, 0,  3, 2, 2, 1, 2, 2, 0};
    vecs[7]  = '{6'h3F, 6'h00, 1'b0, 0, 0,  3, 1, 0, 0, 0, 0, 1};
    vecs[8]  = '{6'h0D, 6'h00, 1'b0, 0, 0,  4, 1, 0, 1, 0, 0, 0};
    vecs[9]  = '{6'h23, 6'h00, 1'b0, 3, 3, 11, 1, 0, 1, 0, 1, 0};
    vecs[10] = '{6'h02, 6'h00, 1'b0, 1, 0,  4, 2, 2, 0, 0, 0, 0};
    vecs[11] = '{6'h05, 6'h00, 1'b0, 0, 0,  3, 2, 1, 0, 0, 0, 0};
    ops = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h3F};

    rst_n = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; opcode = '0; funct = '0;
    #2;
    chk("rst.state", int'(state), int'(FETCH));     chk("rst.mem_read", int'(mem_read), 1);
    chk("rst.iord", int'(iord), 0);                 chk("rst.alu_src_a", int'(alu_src_a), 0);
    chk("rst.alu_src_b", int'(alu_src_b), 1);       chk("rst.alu_op", int'(alu_op), 0);
    chk("rst.strobes", int'({mem_write, ir_write, pc_write, reg_write, illegal_op}), 0);
    chk("rst.mem_timeout", int'(mem_timeout), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].fn, vecs[i].az, vecs[i].fw, vecs[i].mw, o);
      chk($sformatf("vec%0d.cycles", i), o.cycles, vecs[i].cycles);
      chk($sformatf("vec%0d.pc_write_n", i), o.pc_w, vecs[i].pc_w);
      chk($sformatf("vec%0d.pc_source", i), o.pc_src, vecs[i].pc_src);
      chk($sformatf("vec%0d.reg_write_n", i), o.reg_w, vecs[i].reg_w);
      chk($sformatf("vec%0d.reg_dst", i), o.reg_dst, vecs[i].reg_dst);
      chk($sformatf("vec%0d.mem_to_reg", i), o.m2r, vecs[i].m2r);
      chk($sformatf("vec%0d.illegal_n", i), o.ill, vecs[i].ill);
      chk($sformatf("vec%0d.halted", i), o.halted, 0);
    end

    for (int i = 0; i < 60; i++) begin
      logic [5:0] rop, rfn;
      logic       raz;
      int         rfw, rmw, k;
      k   = $urandom_range(0, 13);
      rop = (k == 13) ? 6'($urandom) : ops[k];
      rfn = ($urandom_range(0, 3) == 0) ? FN_JR : 6'($urandom);
      raz = 1'($urandom_range(0, 1));
      rfw = $urandom_range(0, TMO);
      rmw = $urandom_range(0, TMO);
      run_instr(rop, rfn, raz, rfw, rmw, o);
      e = model(rop, rfn, raz, rfw, rmw);
      cmp_obs($sformatf("rnd%0d_op%0h", i, rop), o, e);
    end

    // Watchdog: sw whose write never completes halts after TMO+1 stalled cycles.
    opcode = OP_SW; funct = '0; mem_ready = 1'b1;
    #1 chk("to.fetch_ir_write", int'(ir_write), 1);
    @(negedge clk); mem_ready = 1'b0;
    #1 chk("to.decode_state", int'(state), int'(DECODE));
    chk("to.decode_alu_src_b", int'(alu_src_b), 3);
    chk("to.decode_alu_src_a", int'(alu_src_a), 0);
    @(negedge clk);
    #1 chk("to.mem_addr_alu_src_b", int'(alu_src_b), 2);
    @(negedge clk);
    for (int w = 0; w <= TMO; w++) begin
      #1 chk($sformatf("to.wait%0d_state", w), int'(state), int'(MEM_WRITE));
      chk($sformatf("to.wait%0d_mem_write", w), int'(mem_write), 1);
      chk($sformatf("to.wait%0d_timeout", w), int'(mem_timeout), 0);
      @(negedge clk);
    end
    for (int h = 0; h < 3; h++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1 chk($sformatf("to.halt%0d_state", h), int'(state), int'(HALT));
      chk($sformatf("to.halt%0d_timeout", h), int'(mem_timeout), 1);
      chk($sformatf("to.halt%0d_strobes", h),
          int'({mem_read, mem_write, ir_write, pc_write, reg_write, illegal_op}), 0);
      @(negedge clk);
    end
    rst_n = 1'b0; mem_ready = 1'b0;
    #1 chk("to.reset_timeout", int'(mem_timeout), 0);
    chk("to.reset_state", int'(state), int'(FETCH));
    @(negedge clk); rst_n = 1'b1;

    // Reset asserted mid-write must kill mem_write in the same cycle.
    opcode = OP_SW; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("rw.before_mem_write", int'(mem_write), 1);
    #1 rst_n = 1'b0;
    #1 chk("rw.after_mem_write", int'(mem_write), 0);
    chk("rw.after_state", int'(state), int'(FETCH));
    chk("rw.after_mem_read", int'(mem_read), 1);
    @(negedge clk); rst_n = 1'b1;
    run_instr(OP_RTYPE, 6'h20, 1'b0, 0, 0, o);
    cmp_obs("rw.resume", o, model(OP_RTYPE, 6'h20, 1'b0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Control FSM for the next-generation multi-cycle MIPS core. It replaces the single-cycle combinational control_unit/ALU_CU pair.
- Sequences FETCH/DECODE/EXEC/MEM/WB over a shared instruction/data memory that has a ready handshake with variable wait states.
- Adds a watchdog timeout on memory accesses and illegal-opcode detection.
- Drives every datapath mux select and write strobe of the multi-cycle datapath.

Parameters:
- TIMEOUT_CYCLES, 15: wait cycles allowed per memory access before a halt; 0 disables the watchdog.
- OP_W, 6: opcode width.
- FUNCT_W, 6: funct width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OP_W  IR[31:26], valid from DECODE onward.
- funct  in  FUNCT_W  IR[5:0].
- alu_zero  in  1  ALU zero flag, valid in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC (branch condition already folded in).
- pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = {PC[31:28],IR[25:0],00}, 3 = rs.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2.
- alu_op  out  3  ALU operation code (see package).
- reg_write  out  1  register file write strobe.
- reg_dst  out  2  0 = rt, 1 = rd, 2 = $31.
- mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC.
- illegal_op  out  1  one-cycle pulse on an undecodable instruction.
- mem_timeout  out  1  sticky; set when the watchdog expires.
- state  out  4  current state, for debug.

Behaviour:
- State register is reset asynchronously to FETCH. Wait counter and mem_timeout reset to 0. Outputs are combinational from state, mem_ready and alu_zero.
- Values while in reset / FETCH with mem_ready=0:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_source=0.
  - All other outputs 0.
- FETCH: holds until mem_ready. In the ready cycle ir_write=1 and pc_write=1 (PC+4), then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target into ALUOut). Dispatch on opcode:
  - 0x23 lw, 0x2B sw -> MEM_ADDR
  - 0x00 -> R_EXEC, or JR if funct=0x08
  - 0x04 beq, 0x05 bne -> BRANCH
  - 0x02 -> JUMP
  - 0x03 -> JAL
  - 0x08 addi, 0x0A slti, 0x0C andi, 0x0D ori -> I_EXEC
  - anything else -> ILLEGAL
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD; then MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read=1, iord=1; holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; then FETCH.
- MEM_WRITE: mem_write=1, iord=1; holds until mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=RTYPE; then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=2. alu_op is ADD, SLT, AND or OR per opcode. Then I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_source=1. pc_write = alu_zero for beq, !alu_zero for bne. Then FETCH.
- JUMP: pc_source=2, pc_write=1; then FETCH.
- JAL: pc_source=2, pc_write=1, reg_write=1, reg_dst=2, mem_to_reg=2 (PC already holds PC+4). Then FETCH.
- JR: pc_source=3, pc_write=1; then FETCH.
- ILLEGAL: illegal_op=1 for one cycle, no architectural writes; then FETCH (the instruction is skipped).
- Watchdog:
  - The wait counter clears on entry to FETCH, MEM_READ and MEM_WRITE, and increments each cycle the state waits with mem_ready=0.
  - Width is clog2(TIMEOUT_CYCLES+1).
  - When the count equals TIMEOUT_CYCLES and mem_ready=0: go to HALT and set mem_timeout.
  - If mem_ready arrives in that same cycle, the access completes normally (ready wins).
- HALT: all strobes 0, mem_read=0, mem_write=0. Held until rst_n asserts.
- Reset mid-access: the state returns to FETCH immediately and asynchronously. mem_write drops in the same cycle; no partial write strobe may follow reset.
- Latencies with zero wait states:
  - lw: 5 cycles.
  - sw, R-type, I-type: 4 cycles.
  - branch, j, jal, jr, illegal: 3 cycles.
  - Each wait cycle adds 1.

Decomposition:
- Package mips_pkg:
  - state enum, 4-bit, 16 states: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, JR, ILLEGAL, HALT.
  - Opcode constants.
  - alu_op codes: ADD=000, SUB=001, RTYPE=010, AND=011, OR=100, SLT=101. ALU_CU consumes the same codes.
  - Mux-select constants for pc_source, alu_src_b, reg_dst and mem_to_reg.
- One sub-module: mem_watchdog (counter, expire flag, sticky timeout).

Test Plan:
- lw, mem_ready low 2 cycles in FETCH and 2 in MEM_READ -> 9 cycles total. reg_write=1 with mem_to_reg=1 exactly once. pc_write exactly once.
- beq with alu_zero=1 -> pc_write=1, pc_source=1 in BRANCH. bne with alu_zero=1 -> pc_write=0 in BRANCH.
- jal (opcode 0x03) -> one cycle with pc_write=1, reg_write=1, reg_dst=2, mem_to_reg=2; back in FETCH after 3 cycles.
- TIMEOUT_CYCLES=3 and mem_ready held low in MEM_WRITE -> HALT on the 4th wait cycle, mem_timeout=1. All strobes stay 0 until rst_n=0, which clears mem_timeout.
- Opcode 0x3F -> illegal_op pulses high for exactly 1 cycle with no reg_write, mem_write or extra pc_write; next state is FETCH.
- rst_n pulled low during MEM_WRITE with mem_ready=0 -> mem_write=0 in the same cycle, state=FETCH; after release, fetch resumes normally.
